v_cu_issue_ctrl: RTL and testbench
==================================

# v_cu_issue_ctrl

Vector control-unit issue controller between the scheduler and the V_LANES datapath. It accepts one vector instruction at a time from the scheduler's per-unit valid/ready bundle and checks register hazards against a CHAINING-deep scoreboard of in-flight instructions. It then sequences the instruction into ceil(vl/V_LANES) element-group beats with a per-lane mask. Scoreboard entries are retired by lane completion reports.

## Interface
- VLEN, 4096: vector register length in bits.
- V_LANES, 16: lanes; elements processed per beat.
- CHAINING, 4: scoreboard entries, i.e. maximum in-flight instructions.
- Derived: VL_W = $clog2(VLEN/8)+1, BEAT_W = $clog2(VLEN/(8*V_LANES)), ID_W = $clog2(CHAINING).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr_vld_i  in  11  per-unit valid from scheduler (one-hot expected).
- instr_rdy_o  out  11  per-unit ready to scheduler.
- vector_instr_i  in  32  instruction word.
- sew_i  in  2  element width: 0 = 8b, 1 = 16b, 2 = 32b; 3 is reserved and treated as 2.
- vl_i  in  VL_W  vector length in elements.
- lane_vld_o  out  1  beat valid.
- lane_rdy_i  in  1  lanes accept beat.
- lane_instr_o  out  32  latched instruction.
- lane_unit_o  out  11  one-hot unit of latched instruction.
- lane_beat_o  out  BEAT_W  element-group index.
- lane_mask_o  out  V_LANES  active lanes this beat.
- lane_last_o  out  1  final beat of instruction.
- lane_id_o  out  ID_W  scoreboard tag.
- lane_done_i  in  1  lanes report completion.
- lane_done_id_i  in  ID_W  tag being retired.
- idle_o  out  1  IDLE state and scoreboard empty.

## Operation
- FSM states: IDLE and ISSUE.
- **Unit select:** the lowest set bit of instr_vld_i is selected. Other set bits are never granted that cycle.
- **instr_rdy_o[sel]:** asserted only when all of the following hold:
  - state is IDLE;
  - the scoreboard has a free entry;
  - there is no hazard.
  All other bits are 0.
- **Hazard:** fields [11:7] (vd), [19:15] (vs1) and [24:20] (vs2) are each compared against the vd of every valid entry. Any match is a hazard. All three fields are checked regardless of opcode (conservative).
- **Accept (vld&rdy):**
  - Latch the instruction, the unit and the clamped vl. vl is clamped to max_vl = VLEN/(8<<sew).
  - Allocate the lowest free entry with its vd.
  - Go to ISSUE with beat = 0.
  - vl == 0: accepted but no beats issued and no entry allocated; stay in IDLE.
- **ISSUE:**
  - lane_vld_o is high on every ISSUE cycle.
  - A beat advances on lane_vld_o & lane_rdy_i.
  - lane_mask_o = all ones, except on the last beat, where r = vl − beat·V_LANES and mask = (1<<r)−1 when r < V_LANES.
  - lane_last_o = (beat == ceil(vl/V_LANES)−1).
  - A handshake on the last beat returns the FSM to IDLE.
- **Retire:** lane_done_i clears entry lane_done_id_i. A done on an already-invalid entry is ignored.
- **Retire vs. allocate:** allocation uses the registered free vector, so a retire and an allocation in the same cycle never collide.

## Timing
- **Reset values:**
  - all outputs 0, except idle_o = 1;
  - scoreboard cleared, state IDLE.
  - Reset mid-ISSUE discards the instruction and all entries.
- **Ready timing:** instr_rdy_o is combinational from registered state and the current inputs.
- **First beat:** lane_vld_o is high the cycle after accept.
- **Beat throughput:** beats are back-to-back while lane_rdy_i = 1.
- **Output hold:** all lane_* outputs are registered and hold stable while lane_vld_o & !lane_rdy_i.
- **Issue gap:**
  - last-beat handshake at cycle K → IDLE at K+1;
  - next accept possible at K+1 (one bubble between instructions).
- **Retire visibility:** a retire at cycle K is visible to the hazard check and the free count at K+1.
- **Latency:** an instruction of n beats with no stalls occupies cycles N+1..N+n after accept at N.

## Structure
- **Package v_cu_pkg:**
  - unit index constants (11 units);
  - state enum {IDLE, ISSUE};
  - instruction field offsets for vd, vs1 and vs2;
  - SEW encodings.
- **Sub-module v_cu_scoreboard:**
  - CHAINING valid/vd registers;
  - lowest-free allocator;
  - retire port;
  - 3-way hazard compare;
  - outputs full, empty and hazard.

## Test plan
- **Single instruction, partial last beat:** VLEN 4096, V_LANES 16, sew = 2, vl = 37, lane_rdy_i = 1 → three beats 0, 1, 2 on consecutive cycles; masks FFFF, FFFF, 001F; lane_last_o on beat 2; entry 0 allocated.
- **vl clamp and zero:**
  - sew = 0, vl = 600 → clamped to 512, 32 beats, all masks FFFF;
  - vl = 0 → rdy pulse, no lane_vld_o, idle_o stays 1.
- **Hazard:**
  - in flight: vd = 3;
  - next instruction has vs2 = 3 → instr_rdy_o = 0 until lane_done_i with that id;
  - accept happens exactly one cycle after the retire.
- **Scoreboard full:** four non-conflicting instructions with no retires → fifth instruction gets rdy = 0. One retire of id 2 → fifth accepted into entry 2.
- **Backpressure and multi-valid:**
  - lane_rdy_i toggled 1,0,0,1 → lane_beat_o and lane_mask_o stable during stalls, no beat skipped;
  - instr_vld_i = 0x0A0 → only bit 5 is granted.
- **Reset mid-ISSUE:** rst asserted at beat 1 of a 3-beat instruction → next cycle lane_vld_o = 0, idle_o = 1, scoreboard empty.

Source files
------------

// File: rtl/v_cu_pkg.sv
// Shared constants for the vector control-unit issue path: unit indices,
// FSM state encodings, instruction register-field offsets and SEW codes.
package v_cu_pkg;

    // Functional units served by the scheduler's per-unit valid/ready bundle
    localparam int NUM_UNITS   = 11;
    localparam int UNIT_VALU   = 0;
    localparam int UNIT_VMUL   = 1;
    localparam int UNIT_VDIV   = 2;
    localparam int UNIT_VFPU   = 3;
    localparam int UNIT_VLOAD  = 4;
    localparam int UNIT_VSTORE = 5;
    localparam int UNIT_VRED   = 6;
    localparam int UNIT_VPERM  = 7;
    localparam int UNIT_VMASK  = 8;
    localparam int UNIT_VCFG   = 9;
    localparam int UNIT_VCSR   = 10;

    // Issue FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Vector register fields inside the 32-bit instruction word
    localparam int REG_W   = 5;
    localparam int VD_LSB  = 7;
    localparam int VS1_LSB = 15;
    localparam int VS2_LSB = 20;

    // Element width encodings; the reserved code behaves like 32-bit
    localparam logic [1:0] SEW_8    = 2'd0;
    localparam logic [1:0] SEW_16   = 2'd1;
    localparam logic [1:0] SEW_32   = 2'd2;
    localparam logic [1:0] SEW_RSVD = 2'd3;

endpackage

// File: rtl/v_cu_scoreboard.sv
// Scoreboard of in-flight vector instructions: one valid bit and destination
// register per entry, lowest-free allocation, retire by tag and a
// conservative vd/vs1/vs2 hazard compare against every live destination.
module v_cu_scoreboard
    import v_cu_pkg::*;
#(
    parameter int CHAINING = 4,
    parameter int ID_W     = $clog2(CHAINING)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [REG_W-1:0] alloc_vd,
    output logic [ID_W-1:0]  alloc_id,
    input  logic             retire,
    input  logic [ID_W-1:0]  retire_id,
    input  logic [REG_W-1:0] chk_vd,
    input  logic [REG_W-1:0] chk_vs1,
    input  logic [REG_W-1:0] chk_vs2,
    output logic             full,
    output logic             empty,
    output logic             hazard
);

    logic [CHAINING-1:0] valid;
    logic [REG_W-1:0]    vd_tab [CHAINING];

    assign full  = &valid;
    assign empty = ~|valid;

    // Pick the lowest-numbered free entry from the registered valid vector
    always_comb begin
        alloc_id = '0;
        for (int i = CHAINING - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_id = ID_W'(i);
            end
        end
    end

    // Any source or destination field touching a live vd is a hazard
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < CHAINING; i++) begin
            if (valid[i] && ((vd_tab[i] == chk_vd) ||
                             (vd_tab[i] == chk_vs1) ||
                             (vd_tab[i] == chk_vs2))) begin
                hazard = 1'b1;
            end
        end
    end

    // Retire clears, allocate sets; allocation only targets free entries so
    // a same-cycle retire never lands on the entry being allocated
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (retire) begin
                valid[retire_id] <= 1'b0;
            end
            if (alloc) begin
                valid[alloc_id] <= 1'b1;
            end
        end
    end

    // Record the destination register of each newly allocated entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAINING; i++) begin
                vd_tab[i] <= '0;
            end
        end else if (alloc) begin
            vd_tab[alloc_id] <= alloc_vd;
        end
    end

endmodule

// File: rtl/v_cu_issue_ctrl.sv
// Vector issue controller: grants one scheduler unit at a time when the
// scoreboard has room and no register hazard, then streams the instruction
// to the lanes as ceil(vl/V_LANES) beats with a per-lane element mask.
module v_cu_issue_ctrl
    import v_cu_pkg::*;
#(
    parameter int VLEN     = 4096,
    parameter int V_LANES  = 16,
    parameter int CHAINING = 4,
    parameter int VL_W     = $clog2(VLEN/8) + 1,
    parameter int BEAT_W   = $clog2(VLEN/(8*V_LANES)),
    parameter int ID_W     = $clog2(CHAINING)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] instr_vld_i,
    output logic [NUM_UNITS-1:0] instr_rdy_o,
    input  logic [31:0]          vector_instr_i,
    input  logic [1:0]           sew_i,
    input  logic [VL_W-1:0]      vl_i,
    output logic                 lane_vld_o,
    input  logic                 lane_rdy_i,
    output logic [31:0]          lane_instr_o,
    output logic [NUM_UNITS-1:0] lane_unit_o,
    output logic [BEAT_W-1:0]    lane_beat_o,
    output logic [V_LANES-1:0]   lane_mask_o,
    output logic                 lane_last_o,
    output logic [ID_W-1:0]      lane_id_o,
    input  logic                 lane_done_i,
    input  logic [ID_W-1:0]      lane_done_id_i,
    output logic                 idle_o
);

    logic [0:0]           state;
    logic [NUM_UNITS-1:0] sel;
    logic [1:0]           sew_eff;
    logic [VL_W-1:0]      max_vl;
    logic [VL_W-1:0]      vl_clamped;
    logic [VL_W-1:0]      vl_q;
    logic                 accept;
    logic                 alloc;
    logic                 hazard;
    logic                 full;
    logic                 empty;
    logic [ID_W-1:0]      alloc_id;

    // Returns {last, mask} for a given beat of an instruction of length vl
    function automatic logic [V_LANES:0] beat_info(input logic [VL_W-1:0] vl,
                                                   input logic [BEAT_W-1:0] beat);
        int                 nb;
        int                 rem;
        logic               last;
        logic [V_LANES-1:0] mask;
        nb   = (int'(vl) + V_LANES - 1) / V_LANES;
        rem  = int'(vl) - int'(beat) * V_LANES;
        last = (int'(beat) == nb - 1);
        mask = '1;
        if (last && (rem < V_LANES)) begin
            mask = ~({V_LANES{1'b1}} << rem);
        end
        return {last, mask};
    endfunction

    // Grant decision: lowest requesting unit, clamped vl for the current SEW
    always_comb begin
        sel         = instr_vld_i & (~instr_vld_i + NUM_UNITS'(1));
        sew_eff     = (sew_i == SEW_RSVD) ? SEW_32 : sew_i;
        max_vl      = VL_W'(VLEN/8) >> sew_eff;
        vl_clamped  = (vl_i > max_vl) ? max_vl : vl_i;
        instr_rdy_o = ((state == ST_IDLE) && !full && !hazard) ? sel : '0;
        accept      = |(instr_vld_i & instr_rdy_o);
        alloc       = accept && (vl_clamped != '0);
    end

    v_cu_scoreboard #(
        .CHAINING (CHAINING),
        .ID_W     (ID_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .alloc     (alloc),
        .alloc_vd  (vector_instr_i[VD_LSB +: REG_W]),
        .alloc_id  (alloc_id),
        .retire    (lane_done_i),
        .retire_id (lane_done_id_i),
        .chk_vd    (vector_instr_i[VD_LSB +: REG_W]),
        .chk_vs1   (vector_instr_i[VS1_LSB +: REG_W]),
        .chk_vs2   (vector_instr_i[VS2_LSB +: REG_W]),
        .full      (full),
        .empty     (empty),
        .hazard    (hazard)
    );

    assign lane_vld_o = (state == ST_ISSUE);
    assign idle_o     = (state == ST_IDLE) && empty;

    // Issue FSM: latch on accept, then step beats on each lane handshake;
    // a zero-length instruction is consumed without leaving IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            vl_q         <= '0;
            lane_instr_o <= '0;
            lane_unit_o  <= '0;
            lane_beat_o  <= '0;
            lane_mask_o  <= '0;
            lane_last_o  <= 1'b0;
            lane_id_o    <= '0;
        end else if (state == ST_IDLE) begin
            if (alloc) begin
                state        <= ST_ISSUE;
                vl_q         <= vl_clamped;
                lane_instr_o <= vector_instr_i;
                lane_unit_o  <= sel;
                lane_beat_o  <= '0;
                lane_id_o    <= alloc_id;
                {lane_last_o, lane_mask_o} <= beat_info(vl_clamped, BEAT_W'(0));
            end
        end else begin
            if (lane_rdy_i) begin
                if (lane_last_o) begin
                    state <= ST_IDLE;
                end else begin
                    lane_beat_o <= lane_beat_o + 1'b1;
                    {lane_last_o, lane_mask_o} <=
                        beat_info(vl_q, BEAT_W'(lane_beat_o + 1'b1));
                end
            end
        end
    end

endmodule

// File: tb/tb_v_cu_issue_ctrl.sv
// Directed self-checking bench for v_cu_issue_ctrl: partial last beat, vl
// clamp and zero, hazard stall and release, scoreboard full, backpressure,
// multi-valid grant and reset during issue.
module tb_v_cu_issue_ctrl;
    import v_cu_pkg::*;

    localparam int VLEN     = 4096;
    localparam int V_LANES  = 16;
    localparam int CHAINING = 4;
    localparam int VL_W     = 10;
    localparam int BEAT_W   = 5;
    localparam int ID_W     = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_UNITS-1:0] instr_vld_i;
    logic [NUM_UNITS-1:0] instr_rdy_o;
    logic [31:0]          vector_instr_i;
    logic [1:0]           sew_i;
    logic [VL_W-1:0]      vl_i;
    logic                 lane_vld_o;
    logic                 lane_rdy_i;
    logic [31:0]          lane_instr_o;
    logic [NUM_UNITS-1:0] lane_unit_o;
    logic [BEAT_W-1:0]    lane_beat_o;
    logic [V_LANES-1:0]   lane_mask_o;
    logic                 lane_last_o;
    logic [ID_W-1:0]      lane_id_o;
    logic                 lane_done_i;
    logic [ID_W-1:0]      lane_done_id_i;
    logic                 idle_o;

    int checks = 0;
    int errors = 0;

    v_cu_issue_ctrl #(
        .VLEN     (VLEN),
        .V_LANES  (V_LANES),
        .CHAINING (CHAINING)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_vld_i    (instr_vld_i),
        .instr_rdy_o    (instr_rdy_o),
        .vector_instr_i (vector_instr_i),
        .sew_i          (sew_i),
        .vl_i           (vl_i),
        .lane_vld_o     (lane_vld_o),
        .lane_rdy_i     (lane_rdy_i),
        .lane_instr_o   (lane_instr_o),
        .lane_unit_o    (lane_unit_o),
        .lane_beat_o    (lane_beat_o),
        .lane_mask_o    (lane_mask_o),
        .lane_last_o    (lane_last_o),
        .lane_id_o      (lane_id_o),
        .lane_done_i    (lane_done_i),
        .lane_done_id_i (lane_done_id_i),
        .idle_o         (idle_o)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int vd, input int vs1, input int vs2);
        return {7'd0, 5'(vs2), 5'(vs1), 3'd0, 5'(vd), 7'h57};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_UNITS-1:0] vld, input logic [31:0] instr,
                                 input logic [1:0] sew, input logic [VL_W-1:0] vl);
        instr_vld_i    = vld;
        vector_instr_i = instr;
        sew_i          = sew;
        vl_i           = vl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retireId(input logic [ID_W-1:0] id);
        lane_done_i    = 1'b1;
        lane_done_id_i = id;
        tick();
        lane_done_i    = 1'b0;
        lane_done_id_i = '0;
    endtask

    // Safety net in case the sequence below ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        rst            = 1'b1;
        lane_rdy_i     = 1'b0;
        lane_done_i    = 1'b0;
        lane_done_id_i = '0;
        applyStimulus('0, '0, 2'd0, '0);
        tick();
        tick();
        checkOutput("rst_vld",   32'(lane_vld_o),   32'h0);
        checkOutput("rst_idle",  32'(idle_o),       32'h1);
        checkOutput("rst_rdy",   32'(instr_rdy_o),  32'h0);
        checkOutput("rst_mask",  32'(lane_mask_o),  32'h0);
        checkOutput("rst_last",  32'(lane_last_o),  32'h0);
        checkOutput("rst_beat",  32'(lane_beat_o),  32'h0);
        checkOutput("rst_id",    32'(lane_id_o),    32'h0);
        checkOutput("rst_unit",  32'(lane_unit_o),  32'h0);
        checkOutput("rst_instr", lane_instr_o,      32'h0);
        rst        = 1'b0;
        lane_rdy_i = 1'b1;
        tick();

        $display("[TB] single instruction, sew=32 vl=37");
        applyStimulus(11'h004, mk(1, 2, 4), 2'd2, 10'd37);
        #1;
        checkOutput("t1_rdy", 32'(instr_rdy_o), 32'h004);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t1_b0_vld",   32'(lane_vld_o),  32'h1);
        checkOutput("t1_b0_beat",  32'(lane_beat_o), 32'd0);
        checkOutput("t1_b0_mask",  32'(lane_mask_o), 32'hFFFF);
        checkOutput("t1_b0_last",  32'(lane_last_o), 32'h0);
        checkOutput("t1_b0_id",    32'(lane_id_o),   32'h0);
        checkOutput("t1_b0_unit",  32'(lane_unit_o), 32'h004);
        checkOutput("t1_b0_instr", lane_instr_o,     mk(1, 2, 4));
        checkOutput("t1_b0_idle",  32'(idle_o),      32'h0);
        tick();
        checkOutput("t1_b1_beat",  32'(lane_beat_o), 32'd1);
        checkOutput("t1_b1_mask",  32'(lane_mask_o), 32'hFFFF);
        checkOutput("t1_b1_last",  32'(lane_last_o), 32'h0);
        tick();
        checkOutput("t1_b2_beat",  32'(lane_beat_o), 32'd2);
        checkOutput("t1_b2_mask",  32'(lane_mask_o), 32'h001F);
        checkOutput("t1_b2_last",  32'(lane_last_o), 32'h1);
        tick();
        checkOutput("t1_end_vld",  32'(lane_vld_o),  32'h0);
        checkOutput("t1_end_idle", 32'(idle_o),      32'h0);
        retireId(2'd0);
        checkOutput("t1_retired_idle", 32'(idle_o), 32'h1);

        $display("[TB] vl clamp, sew=8 vl=600");
        applyStimulus(11'h001, mk(5, 6, 7), 2'd0, 10'd600);
        #1;
        checkOutput("t2_rdy", 32'(instr_rdy_o), 32'h001);
        tick();
        applyStimulus('0, '0, 2'd0, '0);
        checkOutput("t2_id", 32'(lane_id_o), 32'h0);
        for (int i = 0; i < 32; i++) begin
            checkOutput($sformatf("t2_beat%0d", i), 32'(lane_beat_o), 32'(i));
            checkOutput($sformatf("t2_mask%0d", i), 32'(lane_mask_o), 32'hFFFF);
            checkOutput($sformatf("t2_last%0d", i), 32'(lane_last_o), (i == 31) ? 32'h1 : 32'h0);
            tick();
        end
        checkOutput("t2_end_vld", 32'(lane_vld_o), 32'h0);
        retireId(2'd0);

        $display("[TB] zero-length instruction");
        applyStimulus(11'h002, mk(8, 9, 10), 2'd2, 10'd0);
        #1;
        checkOutput("t3_rdy", 32'(instr_rdy_o), 32'h002);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t3_vld0",  32'(lane_vld_o), 32'h0);
        checkOutput("t3_idle0", 32'(idle_o),     32'h1);
        tick();
        checkOutput("t3_vld1",  32'(lane_vld_o), 32'h0);
        checkOutput("t3_idle1", 32'(idle_o),     32'h1);

        $display("[TB] hazard on vd=3");
        applyStimulus(11'h001, mk(3, 8, 9), 2'd2, 10'd16);
        #1;
        checkOutput("t4_a_rdy", 32'(instr_rdy_o), 32'h001);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t4_a_last", 32'(lane_last_o), 32'h1);
        checkOutput("t4_a_mask", 32'(lane_mask_o), 32'hFFFF);
        tick();
        checkOutput("t4_a_done_vld", 32'(lane_vld_o), 32'h0);
        applyStimulus(11'h001, mk(3, 11, 12), 2'd2, 10'd16);
        #1;
        checkOutput("t4_haz_vd", 32'(instr_rdy_o), 32'h0);
        applyStimulus(11'h001, mk(10, 3, 12), 2'd2, 10'd16);
        #1;
        checkOutput("t4_haz_vs1", 32'(instr_rdy_o), 32'h0);
        applyStimulus(11'h001, mk(10, 11, 12), 2'd2, 10'd16);
        #1;
        checkOutput("t4_no_haz", 32'(instr_rdy_o), 32'h001);
        applyStimulus(11'h001, mk(10, 11, 3), 2'd2, 10'd16);
        #1;
        checkOutput("t4_haz_vs2", 32'(instr_rdy_o), 32'h0);
        tick();
        checkOutput("t4_haz_vs2_hold", 32'(instr_rdy_o), 32'h0);
        lane_done_i    = 1'b1;
        lane_done_id_i = 2'd0;
        #1;
        checkOutput("t4_retire_cycle", 32'(instr_rdy_o), 32'h0);
        tick();
        lane_done_i = 1'b0;
        #1;
        checkOutput("t4_after_retire", 32'(instr_rdy_o), 32'h001);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t4_b_vld",   32'(lane_vld_o), 32'h1);
        checkOutput("t4_b_id",    32'(lane_id_o),  32'h0);
        checkOutput("t4_b_instr", lane_instr_o,    mk(10, 11, 3));
        tick();
        retireId(2'd0);

        $display("[TB] scoreboard full");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(11'h001, mk(12 + k, 0, 0), 2'd2, 10'd16);
            #1;
            checkOutput($sformatf("t5_rdy%0d", k), 32'(instr_rdy_o), 32'h001);
            tick();
            applyStimulus('0, '0, 2'd2, '0);
            checkOutput($sformatf("t5_id%0d", k), 32'(lane_id_o), 32'(k));
            tick();
        end
        applyStimulus(11'h001, mk(16, 0, 0), 2'd2, 10'd16);
        #1;
        checkOutput("t5_full_rdy", 32'(instr_rdy_o), 32'h0);
        tick();
        checkOutput("t5_full_rdy_hold", 32'(instr_rdy_o), 32'h0);
        checkOutput("t5_full_idle",     32'(idle_o),      32'h0);
        lane_done_i    = 1'b1;
        lane_done_id_i = 2'd2;
        #1;
        checkOutput("t5_retire_cycle", 32'(instr_rdy_o), 32'h0);
        tick();
        lane_done_i = 1'b0;
        #1;
        checkOutput("t5_after_retire", 32'(instr_rdy_o), 32'h001);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t5_fifth_vld", 32'(lane_vld_o), 32'h1);
        checkOutput("t5_fifth_id",  32'(lane_id_o),  32'h2);
        tick();
        for (int k = 0; k < 4; k++) begin
            retireId(ID_W'(k));
        end
        checkOutput("t5_drained_idle", 32'(idle_o), 32'h1);

        $display("[TB] lane backpressure, vl=40");
        applyStimulus(11'h001, mk(20, 21, 22), 2'd2, 10'd40);
        #1;
        checkOutput("t6_rdy", 32'(instr_rdy_o), 32'h001);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t6_b0_beat", 32'(lane_beat_o), 32'd0);
        checkOutput("t6_b0_mask", 32'(lane_mask_o), 32'hFFFF);
        tick();
        checkOutput("t6_b1_beat", 32'(lane_beat_o), 32'd1);
        checkOutput("t6_b1_last", 32'(lane_last_o), 32'h0);
        lane_rdy_i = 1'b0;
        tick();
        checkOutput("t6_stall1_vld",  32'(lane_vld_o),  32'h1);
        checkOutput("t6_stall1_beat", 32'(lane_beat_o), 32'd1);
        checkOutput("t6_stall1_mask", 32'(lane_mask_o), 32'hFFFF);
        tick();
        checkOutput("t6_stall2_beat", 32'(lane_beat_o), 32'd1);
        checkOutput("t6_stall2_mask", 32'(lane_mask_o), 32'hFFFF);
        lane_rdy_i = 1'b1;
        tick();
        checkOutput("t6_b2_beat", 32'(lane_beat_o), 32'd2);
        checkOutput("t6_b2_mask", 32'(lane_mask_o), 32'h00FF);
        checkOutput("t6_b2_last", 32'(lane_last_o), 32'h1);
        tick();
        checkOutput("t6_end_vld", 32'(lane_vld_o), 32'h0);
        retireId(2'd0);

        $display("[TB] multi-valid grant");
        applyStimulus(11'h0A0, mk(23, 24, 25), 2'd2, 10'd16);
        #1;
        checkOutput("t7_rdy", 32'(instr_rdy_o), 32'h020);
        tick();
        checkOutput("t7_busy_rdy", 32'(instr_rdy_o), 32'h0);
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t7_unit", 32'(lane_unit_o), 32'h020);
        checkOutput("t7_vld",  32'(lane_vld_o),  32'h1);
        tick();
        retireId(2'd0);

        $display("[TB] reset during issue");
        applyStimulus(11'h001, mk(26, 27, 28), 2'd2, 10'd40);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t8_b0_beat", 32'(lane_beat_o), 32'd0);
        tick();
        checkOutput("t8_b1_beat", 32'(lane_beat_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t8_rst_vld",  32'(lane_vld_o),  32'h0);
        checkOutput("t8_rst_idle", 32'(idle_o),      32'h1);
        checkOutput("t8_rst_beat", 32'(lane_beat_o), 32'h0);
        applyStimulus(11'h001, mk(29, 26, 26), 2'd2, 10'd16);
        #1;
        checkOutput("t8_empty_rdy", 32'(instr_rdy_o), 32'h001);
        tick();
        applyStimulus('0, '0, 2'd2, '0);
        checkOutput("t8_new_id", 32'(lane_id_o), 32'h0);
        tick();
        retireId(2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
